// File: rtl/tank_bullet_ctrl_if.sv
// Signal bundle between the tank/VGA side and the bullet controller.
// master: the side that drives tank state and the pixel scan (tank logic, bench).
// slave : the bullet controller itself.
interface tank_bullet_ctrl_if;
    logic       frame_clk;
    logic       is_shooting;
    logic [2:0] tank_dir;
    logic [9:0] tank_X;
    logic [9:0] tank_Y;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       is_bullet;
    logic       fire_ack;
    logic [3:0] active_count;

    modport master (
        output frame_clk, is_shooting, tank_dir, tank_X, tank_Y, DrawX, DrawY,
        input  is_bullet, fire_ack, active_count
    );

    modport slave (
        input  frame_clk, is_shooting, tank_dir, tank_X, tank_Y, DrawX, DrawY,
        output is_bullet, fire_ack, active_count
    );
endinterface

// File: rtl/tank_bullet_ctrl.sv
// Bullet pool for the tank game: latches fire requests, spawns projectiles at
// the tank muzzle once per frame, advances/retires them, and reports whether
// the pixel being scanned out is covered by any live bullet.
module tank_bullet_ctrl #(
    parameter int         NUM_SLOTS = 4,
    parameter logic [9:0] SPEED     = 10'd4,
    parameter logic [9:0] SIZE      = 10'd4,
    parameter logic [4:0] COOLDOWN  = 5'd15,
    parameter logic [9:0] TANK_W    = 10'd32,
    parameter logic [9:0] TANK_H    = 10'd32,
    parameter logic [9:0] X_MAX     = 10'd639,
    parameter logic [9:0] Y_MAX     = 10'd479
) (
    input  logic               Clk,
    input  logic               Reset,
    tank_bullet_ctrl_if.slave  bus
);

    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_DOWN  = 3'b100;
    localparam logic [2:0] DIR_LEFT  = 3'b011;
    localparam logic [2:0] DIR_RIGHT = 3'b010;

    // Offsets that centre the bullet square on the tank edge.
    localparam logic [9:0] OFS_X = (TANK_W >> 1) - (SIZE >> 1);
    localparam logic [9:0] OFS_Y = (TANK_H >> 1) - (SIZE >> 1);

    logic                 frame_clk_r;
    logic                 frame_prev_r;
    logic                 tick_s;
    logic                 fire_pend_r;
    logic                 fire_ack_r;
    logic [4:0]           cd_r;
    logic [4:0]           cd_dec_s;
    logic [NUM_SLOTS-1:0] act_r;
    logic [NUM_SLOTS-1:0] act_n_s;
    logic [9:0]           x_r     [NUM_SLOTS];
    logic [9:0]           y_r     [NUM_SLOTS];
    logic [2:0]           dir_r   [NUM_SLOTS];
    logic [9:0]           x_n_s   [NUM_SLOTS];
    logic [9:0]           y_n_s   [NUM_SLOTS];
    logic [2:0]           dir_n_s [NUM_SLOTS];
    logic [3:0]           count_r;
    logic [3:0]           count_n_s;
    logic [20:0]          mv_s;
    logic                 dir_ok_s;
    logic                 free_s;
    logic [2:0]           sel_s;
    logic                 spawn_s;
    logic [9:0]           mz_x_s;
    logic [9:0]           mz_y_s;
    logic                 hit_s;

    // One frame step for a flying bullet: {alive, x, y}. Compares are done one
    // bit wider so that a bullet near an edge retires instead of wrapping.
    function automatic logic [20:0] move_slot(input logic [2:0] d,
                                              input logic [9:0] x,
                                              input logic [9:0] y);
        logic       alive;
        logic [9:0] xn;
        logic [9:0] yn;
        alive = 1'b1;
        xn    = x;
        yn    = y;
        case (d)
            DIR_UP:    if ({1'b0, y} < {1'b0, SPEED}) alive = 1'b0;
                       else yn = y - SPEED;
            DIR_DOWN:  if ({1'b0, y} + {1'b0, SIZE} + {1'b0, SPEED} > {1'b0, Y_MAX}) alive = 1'b0;
                       else yn = y + SPEED;
            DIR_LEFT:  if ({1'b0, x} < {1'b0, SPEED}) alive = 1'b0;
                       else xn = x - SPEED;
            DIR_RIGHT: if ({1'b0, x} + {1'b0, SIZE} + {1'b0, SPEED} > {1'b0, X_MAX}) alive = 1'b0;
                       else xn = x + SPEED;
            // A slot only ever holds a valid heading; anything else is dropped.
            default:   alive = 1'b0;
        endcase
        return {alive, xn, yn};
    endfunction

    assign tick_s   = frame_clk_r & ~frame_prev_r;
    // The cooldown expires on the tick that counts it down to zero.
    assign cd_dec_s = (cd_r != 5'd0) ? (cd_r - 5'd1) : 5'd0;

    // Muzzle position for the current heading; up/left saturate at the screen edge.
    always_comb begin
        mz_x_s   = bus.tank_X;
        mz_y_s   = bus.tank_Y;
        dir_ok_s = 1'b1;
        case (bus.tank_dir)
            DIR_UP: begin
                mz_x_s = bus.tank_X + OFS_X;
                mz_y_s = (bus.tank_Y < SIZE) ? 10'd0 : (bus.tank_Y - SIZE);
            end
            DIR_DOWN: begin
                mz_x_s = bus.tank_X + OFS_X;
                mz_y_s = bus.tank_Y + TANK_H;
            end
            DIR_LEFT: begin
                mz_x_s = (bus.tank_X < SIZE) ? 10'd0 : (bus.tank_X - SIZE);
                mz_y_s = bus.tank_Y + OFS_Y;
            end
            DIR_RIGHT: begin
                mz_x_s = bus.tank_X + TANK_W;
                mz_y_s = bus.tank_Y + OFS_Y;
            end
            default: dir_ok_s = 1'b0;
        endcase
    end

    // Slot allocation (from pre-tick occupancy) plus per-slot move/retire/spawn.
    always_comb begin
        free_s    = 1'b0;
        sel_s     = 3'd0;
        mv_s      = 21'd0;
        count_n_s = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sel_s  = (!act_r[i] && !free_s) ? 3'(i) : sel_s;
            free_s = free_s | ~act_r[i];
        end
        spawn_s = tick_s & (fire_pend_r | bus.is_shooting) & (cd_dec_s == 5'd0)
                  & dir_ok_s & free_s;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            mv_s = move_slot(dir_r[i], x_r[i], y_r[i]);
            if (spawn_s && (sel_s == 3'(i))) begin
                act_n_s[i] = 1'b1;
                x_n_s[i]   = mz_x_s;
                y_n_s[i]   = mz_y_s;
                dir_n_s[i] = bus.tank_dir;
            end else if (tick_s && act_r[i]) begin
                act_n_s[i] = mv_s[20];
                x_n_s[i]   = mv_s[19:10];
                y_n_s[i]   = mv_s[9:0];
                dir_n_s[i] = dir_r[i];
            end else begin
                act_n_s[i] = act_r[i];
                x_n_s[i]   = x_r[i];
                y_n_s[i]   = y_r[i];
                dir_n_s[i] = dir_r[i];
            end
            count_n_s = count_n_s + {3'b000, act_n_s[i]};
        end
    end

    // Pixel hit test against every live bullet square.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_s = hit_s | (act_r[i]
                    & ({1'b0, x_r[i]} <= {1'b0, bus.DrawX})
                    & ({1'b0, bus.DrawX} < ({1'b0, x_r[i]} + {1'b0, SIZE}))
                    & ({1'b0, y_r[i]} <= {1'b0, bus.DrawY})
                    & ({1'b0, bus.DrawY} < ({1'b0, y_r[i]} + {1'b0, SIZE})));
        end
    end

    // Frame edge detect, fire latch, cooldown and slot state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_r  <= 1'b0;
            frame_prev_r <= 1'b0;
            fire_pend_r  <= 1'b0;
            fire_ack_r   <= 1'b0;
            cd_r         <= 5'd0;
            act_r        <= '0;
            count_r      <= 4'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_r[i]   <= 10'd0;
                y_r[i]   <= 10'd0;
                dir_r[i] <= 3'd0;
            end
        end else begin
            frame_clk_r  <= bus.frame_clk;
            frame_prev_r <= frame_clk_r;
            fire_pend_r  <= tick_s ? 1'b0 : (fire_pend_r | bus.is_shooting);
            fire_ack_r   <= spawn_s;
            cd_r         <= spawn_s ? COOLDOWN : (tick_s ? cd_dec_s : cd_r);
            act_r        <= act_n_s;
            count_r      <= count_n_s;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_r[i]   <= x_n_s[i];
                y_r[i]   <= y_n_s[i];
                dir_r[i] <= dir_n_s[i];
            end
        end
    end

    assign bus.is_bullet    = hit_s;
    assign bus.fire_ack     = fire_ack_r;
    assign bus.active_count = count_r;

endmodule

// File: tb/tb_tank_bullet_ctrl.sv
// Directed bench for tank_bullet_ctrl: a spawn-position vector table, a pixel
// hit table, and hand-written multi-frame sequences.
module tb_tank_bullet_ctrl;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;
    logic ack;

    tank_bullet_ctrl_if bus_if ();

    tank_bullet_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] dir;
        int         tx;
        int         ty;
        int         exp_ack;
        int         ex;
        int         ey;
    } spawn_vec_t;

    typedef struct {
        int x;
        int y;
        int exp_hit;
    } pix_vec_t;

    spawn_vec_t svec [8];
    pix_vec_t   pvec [6];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus_if.frame_clk   = 1'b0;
        bus_if.is_shooting = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
    endtask

    // One frame: rising frame_clk, then sample fire_ack right after the update edge.
    task automatic do_tick(output logic ack_o);
        bus_if.frame_clk = 1'b1;
        step();
        step();
        ack_o = bus_if.fire_ack;
        bus_if.frame_clk = 1'b0;
        step();
        step();
    endtask

    task automatic fire_pulse();
        bus_if.is_shooting = 1'b1;
        step();
        bus_if.is_shooting = 1'b0;
        step();
    endtask

    task automatic pix(input string name, input int x, input int y, input int exp_v);
        bus_if.DrawX = 10'(x);
        bus_if.DrawY = 10'(y);
        #1;
        chk(name, int'(bus_if.is_bullet), exp_v);
    endtask

    task automatic set_tank(input logic [2:0] d, input int x, input int y);
        bus_if.tank_dir = d;
        bus_if.tank_X   = 10'(x);
        bus_if.tank_Y   = 10'(y);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        bus_if.frame_clk   = 1'b0;
        bus_if.is_shooting = 1'b0;
        bus_if.DrawX       = 10'd0;
        bus_if.DrawY       = 10'd0;
        set_tank(3'b001, 500, 240);

        // dir, tank_X, tank_Y, ack expected, muzzle X, muzzle Y
        svec[0] = '{3'b001, 500, 240, 1, 514, 236};
        svec[1] = '{3'b100, 100,  50, 1, 114,  82};
        svec[2] = '{3'b011, 200, 300, 1, 196, 314};
        svec[3] = '{3'b010, 600, 100, 1, 632, 114};
        svec[4] = '{3'b001,  50,   2, 1,  64,   0};
        svec[5] = '{3'b011,   2, 100, 1,   0, 114};
        svec[6] = '{3'b000, 100, 100, 0,   0,   0};
        svec[7] = '{3'b111, 100, 100, 0,   0,   0};

        // pixel hits around a bullet at (100,100)
        pvec[0] = '{100, 100, 1};
        pvec[1] = '{103, 103, 1};
        pvec[2] = '{104, 100, 0};
        pvec[3] = '{ 99, 100, 0};
        pvec[4] = '{100, 104, 0};
        pvec[5] = '{100,  99, 0};

        // Reset state
        do_reset();
        chk("rst_count", int'(bus_if.active_count), 0);
        chk("rst_ack", int'(bus_if.fire_ack), 0);
        pix("rst_pix", 0, 0, 0);

        // Spawn position table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_tank(svec[i].dir, svec[i].tx, svec[i].ty);
            fire_pulse();
            do_tick(ack);
            chk($sformatf("spawn%0d_ack", i), int'(ack), svec[i].exp_ack);
            chk($sformatf("spawn%0d_cnt", i), int'(bus_if.active_count), svec[i].exp_ack);
            if (svec[i].exp_ack == 1) begin
                pix($sformatf("spawn%0d_tl", i), svec[i].ex, svec[i].ey, 1);
                pix($sformatf("spawn%0d_br", i), svec[i].ex + 3, svec[i].ey + 3, 1);
                pix($sformatf("spawn%0d_rt", i), svec[i].ex + 4, svec[i].ey, 0);
                if (svec[i].ex > 0) pix($sformatf("spawn%0d_lf", i), svec[i].ex - 1, svec[i].ey, 0);
                if (svec[i].ey > 0) pix($sformatf("spawn%0d_up", i), svec[i].ex, svec[i].ey - 1, 0);
            end
        end

        // Upward bullet advances 4 px on the following frame
        do_reset();
        set_tank(3'b001, 500, 240);
        fire_pulse();
        do_tick(ack);
        do_tick(ack);
        chk("move_ack", int'(ack), 0);
        pix("move_new", 514, 232, 1);
        pix("move_old", 514, 236, 0);

        // Right bullet at X=632 retires on the next frame
        do_reset();
        set_tank(3'b010, 600, 100);
        fire_pulse();
        do_tick(ack);
        do_tick(ack);
        chk("retire_cnt", int'(bus_if.active_count), 0);
        pix("retire_pix", 632, 114, 0);

        // Held fire: accepted on frames 0,15,30,45; pool full on frame 60
        do_reset();
        set_tank(3'b100, 300, 0);
        bus_if.is_shooting = 1'b1;
        for (int t = 0; t <= 60; t++) begin
            do_tick(ack);
            chk($sformatf("hold_ack_t%0d", t), int'(ack), ((t % 15 == 0) && (t <= 45)) ? 1 : 0);
            chk($sformatf("hold_cnt_t%0d", t), int'(bus_if.active_count), (t >= 45) ? 4 : (t / 15 + 1));
        end
        bus_if.is_shooting = 1'b0;

        // Two pulses in one frame give a single shot
        do_reset();
        set_tank(3'b001, 500, 240);
        fire_pulse();
        fire_pulse();
        do_tick(ack);
        chk("dbl_ack1", int'(ack), 1);
        chk("dbl_cnt1", int'(bus_if.active_count), 1);
        do_tick(ack);
        chk("dbl_ack2", int'(ack), 0);
        chk("dbl_cnt2", int'(bus_if.active_count), 1);

        // Slot1 placed at (100,100) after the cooldown, then pixel table
        do_reset();
        set_tank(3'b001, 500, 400);
        fire_pulse();
        do_tick(ack);
        chk("pix_slot0_ack", int'(ack), 1);
        set_tank(3'b100, 86, 68);
        bus_if.is_shooting = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            do_tick(ack);
            chk($sformatf("cool_ack_t%0d", t), int'(ack), 0);
        end
        do_tick(ack);
        bus_if.is_shooting = 1'b0;
        chk("pix_slot1_ack", int'(ack), 1);
        chk("pix_cnt", int'(bus_if.active_count), 2);
        for (int i = 0; i < 6; i++) begin
            pix($sformatf("pix%0d_%0d_%0d", i, pvec[i].x, pvec[i].y), pvec[i].x, pvec[i].y, pvec[i].exp_hit);
        end

        // Reset with three bullets in flight, then invalid heading after reset
        do_reset();
        set_tank(3'b100, 300, 0);
        bus_if.is_shooting = 1'b1;
        for (int t = 0; t <= 30; t++) begin
            do_tick(ack);
        end
        bus_if.is_shooting = 1'b0;
        chk("mid_cnt", int'(bus_if.active_count), 3);
        pix("mid_pix", 314, 152, 1);
        Reset = 1'b1;
        step();
        chk("mid_rst_cnt", int'(bus_if.active_count), 0);
        pix("mid_rst_pix", 314, 152, 0);
        Reset = 1'b0;
        step();
        set_tank(3'b000, 300, 200);
        fire_pulse();
        do_tick(ack);
        chk("bad_dir_ack", int'(ack), 0);
        chk("bad_dir_cnt", int'(bus_if.active_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tank_bullet_ctrl.md
Name: tank_bullet_ctrl

Overview:
Consumes the fire request, heading and position published by the tank movement block and manages a small pool of in-flight projectiles. Spawns bullets at the tank muzzle, advances them once per frame, retires them at the screen edge, and gives the colour mapper a per-pixel hit flag. Sits beside the tank controller, between the keyboard-driven tank logic and the VGA colour mapper.

Parameters:
NUM_SLOTS, 4, number of simultaneous bullets (1..8)
SPEED, 10'd4, pixels moved per frame
SIZE, 10'd4, bullet square side in pixels
COOLDOWN, 5'd15, frames between accepted shots
TANK_W, 10'd32, tank width used for muzzle offset
TANK_H, 10'd32, tank height used for muzzle offset
X_MAX, 10'd639, rightmost screen column
Y_MAX, 10'd479, bottom screen row

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  frame strobe (~60 Hz, level signal)
is_shooting  in  1  fire request, may be a single-Clk pulse
tank_dir  in  3  heading: 001 up, 100 down, 011 left, 010 right; other codes invalid
tank_X  in  10  tank top-left X
tank_Y  in  10  tank top-left Y
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
is_bullet  out  1  current pixel lies inside any active bullet
fire_ack  out  1  one-Clk pulse when a shot is spawned
active_count  out  4  number of active slots

Behaviour:
- Frame tick: frame_clk is registered and edge-detected. tick asserts for exactly one Clk, one cycle after a 0->1 transition. All slot updates happen only on tick.
- Fire latch: fire_pend is set on any Clk with is_shooting=1 and cleared on tick. A pulse between ticks is never lost, and multiple pulses within one frame count as one request.
- Per-slot state: ACTIVE bit, X[9:0], Y[9:0], dir[2:0]. Slots are either IDLE or FLYING.
- On tick, per FLYING slot, apply move or retire:
  - up: Y < SPEED -> IDLE, else Y -= SPEED.
  - down: Y+SIZE+SPEED > Y_MAX -> IDLE, else Y += SPEED.
  - left: X < SPEED -> IDLE, else X -= SPEED.
  - right: X+SIZE+SPEED > X_MAX -> IDLE, else X += SPEED.
  - All compares use 11-bit unsigned arithmetic, so there is no wrap-around.
- Cooldown: cd counter is decremented on tick while nonzero.
- Spawn on tick, when all of the following hold: fire_pend (or is_shooting in the same cycle), cd==0, tank_dir valid, and a free slot exists.
  - Target is the lowest-index IDLE slot, evaluated before the same tick's retirements.
  - Position is the muzzle, centred on the tank edge:
    - up: X=tank_X+TANK_W/2-SIZE/2, Y=tank_Y-SIZE, saturating at 0.
    - down: same X, Y=tank_Y+TANK_H.
    - left: X=tank_X-SIZE (saturating at 0), Y=tank_Y+TANK_H/2-SIZE/2.
    - right: X=tank_X+TANK_W, same Y.
  - A spawned bullet does not move on its spawn tick.
  - Side effects: cd <= COOLDOWN, fire_ack pulses on the same Clk as the spawn, fire_pend clears.
- Refused requests (pool full, cooldown, or invalid dir) are dropped, with no ack.
- Simultaneous retire and spawn in the same tick: the freed slot is not reusable until the next tick.
- is_bullet is combinational: OR over slots of ACTIVE and X<=DrawX<X+SIZE and Y<=DrawY<Y+SIZE.
- active_count is registered and equals the popcount of ACTIVE bits after the update.
- Reset values: all slots IDLE, X/Y/dir=0, cd=0, fire_pend=0, is_bullet=0, fire_ack=0, active_count=0, frame_clk edge register=0. Reset asserted mid-flight clears everything on the next Clk edge, and the first tick after release needs a fresh 0->1 on frame_clk.

Test Plan:
1. Reset, tank (500,240), dir=001, is_shooting pulse mid-frame -> next tick: fire_ack=1, slot0 at (514,236), active_count=1; following tick Y=232.
2. dir=010 at tank_X=600, fire -> spawn X=632; next tick 632+4+4>639 -> slot retires, active_count=0, no is_bullet afterwards.
3. Hold is_shooting every frame, dir=100 -> shots accepted on ticks 0,15,30,45 only; fifth request with 4 active slots (far from edge) refused, fire_ack low.
4. Two is_shooting pulses in one frame -> exactly one spawn, one fire_ack.
5. Slot1 at (100,100) -> DrawX/Y=(100,100) and (103,103) give is_bullet=1; (104,100) and (99,100) give 0.
6. Reset asserted with 3 bullets flying -> next Clk active_count=0, is_bullet=0; dir=000 with fire after reset -> no spawn.
